// File: rtl/peripheral_slave.sv
// rtl/peripheral_slave.sv - AXI4-Lite responder exposing a bank of 32-bit registers with a write strobe
// Optional feature macro: PERI_SLAVE_DECERR_EN (out-of-range accesses answer SLVERR instead of wrapping)
module peripheral_slave #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 12
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic [31:0]            S_AXI_AWADDR,
  input  logic                   S_AXI_AWPROT,
  input  logic                   S_AXI_AWVALID,
  output logic                   S_AXI_AWREADY,
  input  logic [31:0]            S_AXI_WDATA,
  input  logic [3:0]             S_AXI_WSTRB,
  input  logic                   S_AXI_WVALID,
  output logic                   S_AXI_WREADY,
  output logic [1:0]             S_AXI_BRESP,
  output logic                   S_AXI_BVALID,
  input  logic                   S_AXI_BREADY,
  input  logic [31:0]            S_AXI_ARADDR,
  input  logic                   S_AXI_ARPROT,
  input  logic                   S_AXI_ARVALID,
  output logic                   S_AXI_ARREADY,
  output logic [31:0]            S_AXI_RDATA,
  output logic [1:0]             S_AXI_RRESP,
  output logic                   S_AXI_RVALID,
  input  logic                   S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0] REG_OUT,
  output logic                   WR_STROBE,
  output logic [5:0]             WR_INDEX
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] NREG_IDX = IDX_W'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef PERI_SLAVE_DECERR_EN
  localparam logic [1:0] MISS_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] MISS_RESP = RESP_OKAY;
  localparam logic [IDX_W-1:0] SEL_MASK = IDX_W'((1 << $clog2(NUM_REGS)) - 1);
`endif

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Without error decode the word index wraps onto the low bits of the bank.
  function automatic logic [IDX_W-1:0] map_idx(input logic [IDX_W-1:0] idx);
`ifdef PERI_SLAVE_DECERR_EN
    return idx;
`else
    return idx & SEL_MASK;
`endif
  endfunction

  w_state_t         w_state, w_state_n;
  r_state_t         r_state, r_state_n;
  logic             aw_lat, aw_lat_n, w_lat, w_lat_n;
  logic [IDX_W-1:0] aw_sel, aw_sel_n;
  logic [31:0]      wdata_q, wdata_n;
  logic [3:0]       wstrb_q, wstrb_n;
  logic             awready_q, awready_n, wready_q, wready_n;
  logic             bvalid_q, bvalid_n;
  logic [1:0]       bresp_q, bresp_n;
  logic             wr_strobe_n;
  logic [5:0]       wr_index_n;
  logic             commit, aw_hit;
  logic             arready_q, arready_n, rvalid_q, rvalid_n;
  logic [31:0]      rdata_q, rdata_n;
  logic [1:0]       rresp_q, rresp_n;
  logic [IDX_W-1:0] ar_sel;
  logic             ar_hit;
  logic [31:0]      ar_data;
  logic             unused_inputs;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[31:ADDR_W], S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[31:ADDR_W], S_AXI_ARADDR[1:0]};

  assign aw_hit = aw_sel < NREG_IDX;

  always_comb begin
    w_state_n   = w_state;
    aw_lat_n    = aw_lat;
    w_lat_n     = w_lat;
    aw_sel_n    = aw_sel;
    wdata_n     = wdata_q;
    wstrb_n     = wstrb_q;
    bvalid_n    = bvalid_q;
    bresp_n     = bresp_q;
    wr_strobe_n = 1'b0;
    wr_index_n  = WR_INDEX;
    commit      = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_lat && w_lat) begin
          commit      = 1'b1;
          w_state_n   = W_RESP;
          bvalid_n    = 1'b1;
          bresp_n     = aw_hit ? RESP_OKAY : MISS_RESP;
          wr_strobe_n = aw_hit;
          wr_index_n  = 6'(aw_sel);
        end else begin
          if (S_AXI_AWVALID && awready_q) begin
            aw_lat_n = 1'b1;
            aw_sel_n = map_idx(S_AXI_AWADDR[ADDR_W-1:2]);
          end
          if (S_AXI_WVALID && wready_q) begin
            w_lat_n = 1'b1;
            wdata_n = S_AXI_WDATA;
            wstrb_n = S_AXI_WSTRB;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_state_n = W_IDLE;
          bvalid_n  = 1'b0;
          bresp_n   = RESP_OKAY;
          aw_lat_n  = 1'b0;
          w_lat_n   = 1'b0;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
    // Ready flags are registered so they are low in reset and rise on the first edge after it.
    awready_n = (w_state_n == W_IDLE) && !aw_lat_n;
    wready_n  = (w_state_n == W_IDLE) && !w_lat_n;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state   <= W_IDLE;
      aw_lat    <= 1'b0;
      w_lat     <= 1'b0;
      aw_sel    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      WR_STROBE <= 1'b0;
      WR_INDEX  <= '0;
    end else begin
      w_state   <= w_state_n;
      aw_lat    <= aw_lat_n;
      w_lat     <= w_lat_n;
      aw_sel    <= aw_sel_n;
      wdata_q   <= wdata_n;
      wstrb_q   <= wstrb_n;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      bvalid_q  <= bvalid_n;
      bresp_q   <= bresp_n;
      WR_STROBE <= wr_strobe_n;
      WR_INDEX  <= wr_index_n;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    logic [31:0] reg_q;
    logic        hit;
    assign hit = commit && aw_hit && (aw_sel == IDX_W'(k));
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
        reg_q <= '0;
      end else if (hit) begin
        for (int b = 0; b < 4; b++)
          if (wstrb_q[b]) reg_q[8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
    assign REG_OUT[32*k +: 32] = reg_q;
  end

  // Read mux sees pre-commit contents, so a read on the commit edge returns the old value.
  always_comb begin
    ar_sel  = map_idx(S_AXI_ARADDR[ADDR_W-1:2]);
    ar_hit  = ar_sel < NREG_IDX;
    ar_data = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (ar_sel == IDX_W'(k)) ar_data = REG_OUT[32*k +: 32];
  end

  always_comb begin
    r_state_n = r_state;
    rvalid_n  = rvalid_q;
    rdata_n   = rdata_q;
    rresp_n   = rresp_q;
    case (r_state)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          r_state_n = R_DATA;
          rvalid_n  = 1'b1;
          rdata_n   = ar_data;
          rresp_n   = ar_hit ? RESP_OKAY : MISS_RESP;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          r_state_n = R_IDLE;
          rvalid_n  = 1'b0;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
    arready_n = (r_state_n == R_IDLE);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state   <= r_state_n;
      arready_q <= arready_n;
      rvalid_q  <= rvalid_n;
      rdata_q   <= rdata_n;
      rresp_q   <= rresp_n;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_peripheral_slave.sv
// tb/tb_peripheral_slave.sv - randomized self-checking bench for peripheral_slave against a register-array model
`timescale 1ns/1ps
module tb_peripheral_slave;
  localparam int NREG = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [31:0]       awaddr, wdata, araddr, rdata;
  logic              awprot, arprot, awvalid, awready, wvalid, wready;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  logic              bvalid, bready, arvalid, arready, rvalid, rready;
  logic [32*NREG-1:0] reg_out;
  logic              wr_strobe;
  logic [5:0]        wr_index;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [NREG];

  peripheral_slave #(.NUM_REGS(NREG), .ADDR_W(12)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .REG_OUT(reg_out), .WR_STROBE(wr_strobe), .WR_INDEX(wr_index)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register addressed by a byte address, or -1 when no register is hit.
  function automatic int target(input logic [31:0] addr);
    int idx;
    idx = int'(addr % 32'd4096) / 4;
`ifdef PERI_SLAVE_DECERR_EN
    return (idx < NREG) ? idx : -1;
`else
    return idx % NREG;
`endif
  endfunction

  function automatic logic [1:0] exp_resp(input int r);
    return (r < 0) ? 2'b10 : 2'b00;
  endfunction

  task automatic check_regs();
    for (int k = 0; k < NREG; k++)
      check($sformatf("reg_out[%0d]", k), reg_out[32*k +: 32], model[k]);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    int r, cyc;
    logic aw_done, w_done, aw_hs, w_hs;
    r = target(addr);
    awaddr = addr; wdata = data; wstrb = strb;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_handshake", aw_done && w_done, 1'b1);
    check("bvalid_early", bvalid, 1'b0);
    tick();
    if (r >= 0)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[r][8*b +: 8] = data[8*b +: 8];
    check("bvalid", bvalid, 1'b1);
    check("bresp", bresp, exp_resp(r));
    check("wr_strobe", wr_strobe, r >= 0);
    if (r >= 0) check("wr_index", wr_index, r);
    check_regs();
    for (int i = 0; i < b_dly; i++) begin
      check("awready_in_resp", awready, 1'b0);
      tick();
      check("bvalid_hold", bvalid, 1'b1);
      check("wr_strobe_pulse", wr_strobe, 1'b0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bvalid_clear", bvalid, 1'b0);
    check("wr_strobe_end", wr_strobe, 1'b0);
    check("awready_back", awready, 1'b1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
    int r, cyc;
    logic hs;
    logic [31:0] exp;
    r = target(addr);
    exp = (r >= 0) ? model[r] : 32'h0;
    araddr = addr;
    for (int i = 0; i < ar_dly; i++) tick();
    arvalid = 1'b1;
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 20) begin
      hs = arready;
      tick();
      cyc++;
    end
    arvalid = 1'b0;
    check("rd_handshake", hs, 1'b1);
    check("rvalid", rvalid, 1'b1);
    check("rdata", rdata, exp);
    check("rresp", rresp, exp_resp(r));
    for (int i = 0; i < r_dly; i++) begin
      tick();
      check("rvalid_hold", rvalid, 1'b1);
      check("rdata_hold", rdata, exp);
      check("arready_busy", arready, 1'b0);
    end
    rready = 1'b1;
    check("arready_before_hs", arready, 1'b0);
    tick();
    rready = 1'b0;
    check("rvalid_clear", rvalid, 1'b0);
    check("arready_back", arready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awprot = 1'b0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = 1'b0; arvalid = 1'b0; rready = 1'b0;
    for (int k = 0; k < NREG; k++) model[k] = 32'h0;
    tick(); tick();
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_bresp", bresp, 2'b00);
    check("rst_rresp", rresp, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    check("rst_reg_out_nonzero", |reg_out, 1'b0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_wr_index", wr_index, 6'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("awready_before_edge", awready, 1'b0);
    tick();
    check("awready_after_rst", awready, 1'b1);
    check("wready_after_rst", wready, 1'b1);
    check("arready_after_rst", arready, 1'b1);

    do_write(32'h004, 32'hDEADBEEF, 4'hF, 0, 0, 1);
    check("reg1_deadbeef", reg_out[63:32], 32'hDEADBEEF);
    do_read(32'h004, 0, 0);

    do_write(32'h008, 32'h11223344, 4'hF, 0, 0, 0);
    do_write(32'h008, 32'hAABBCCDD, 4'b0101, 2, 0, 0);
    check("reg2_merge", reg_out[95:64], 32'h11BB33DD);

    do_write(32'h008, 32'hFFFFFFFF, 4'h0, 0, 1, 0);
    check("reg2_nostrb", reg_out[95:64], 32'h11BB33DD);

    do_write(32'h020, 32'h0BADF00D, 4'hF, 1, 0, 2);
`ifdef PERI_SLAVE_DECERR_EN
    check("oob_reg0", reg_out[31:0], 32'h0);
`else
    check("wrap_reg0", reg_out[31:0], 32'h0BADF00D);
`endif
    do_read(32'h020, 0, 1);

    // Read of reg 3 captured on the same edge as a write commit to reg 3.
    do_write(32'h00C, 32'hCAFE0003, 4'hF, 0, 0, 0);
    awaddr = 32'h00C; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h00C; arvalid = 1'b1;
    check("arready_same_edge", arready, 1'b1);
    tick();
    arvalid = 1'b0;
    check("same_edge_rvalid", rvalid, 1'b1);
    check("same_edge_rdata_old", rdata, 32'hCAFE0003);
    check("same_edge_bvalid", bvalid, 1'b1);
    check("same_edge_reg3", reg_out[127:96], 32'h5);
    model[3] = 32'h5;
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    check("same_edge_bclear", bvalid, 1'b0);
    check("same_edge_rclear", rvalid, 1'b0);
    do_read(32'h00C, 0, 0);

    do_read(32'h008, 0, 5);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 7) << 12);
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset while the write response is pending.
    awaddr = 32'h010; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("pre_rst_bvalid", bvalid, 1'b1);
    check("pre_rst_reg4", reg_out[159:128], 32'h12345678);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NREG; k++) model[k] = 32'h0;
    check("async_rst_bvalid", bvalid, 1'b0);
    check("async_rst_awready", awready, 1'b0);
    check_regs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst2_awready_low", awready, 1'b0);
    tick();
    check("rst2_awready", awready, 1'b1);
    check("rst2_wready", wready, 1'b1);
    check("rst2_bvalid", bvalid, 1'b0);
    do_read(32'h004, 0, 0);
    do_write(32'h01C, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    do_read(32'h01C, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
